alien_row: RTL and testbench
============================

# alien_row

Sprite generator for one row of five marching invaders in the 640x480 VGA pipeline. It keeps the formation position and compares it against the live `pixel_row`/`pixel_column` from the display timing generator. It reports which alien covers the current pixel and the pixel intensity to draw. It also raises `loser` once the row has descended to the landing line. The top level instantiates it three times (rows A, B, C) with different parameters.

## Interface
- `Y_START`, 64: top y of the row after reset.
- `X_START`, 96: left x of alien 1 after reset.
- `SPACING`, 64: x pitch between adjacent aliens.
- `STEP_X`, 4: horizontal pixels per move step.
- `STEP_FRAMES`, 8: frames per move step.
- `DROP`, 16: y increment on each direction reversal.
- `LOSE_Y`, 400: landing line (y coordinate).
- `COLOR`, 4'hF: intensity driven on lit sprite pixels.
- `clk` in 1: pixel clock; the block's only clock.
- `rst` in 1: synchronous, active-low reset.
- `pixel_row` in 12: current scan row; values above 479 are blanking.
- `pixel_column` in 12: current scan column.
- `alien_output` out 4: `COLOR` when any `alienN_active` is high, else 0.
- `alien1_active`..`alien5_active` out 1 each: alien N has a lit pixel at the current position.
- `loser` out 1: sticky; the row reached `LOSE_Y`.

## Operation
- Sprite size is 32 wide x 24 high. Alien N (N = 1..5) occupies x in [x_pos+(N-1)*SPACING, +32) and y in [y_pos, y_pos+24).
- `alienN_active` = pixel inside alien N's box AND the bitmap bit at (row-y_pos, col-x_left) is 1.
- Bitmap bit (12,16) must be 1. Bits (0,0) and (0,31) must be 0.
- Frame tick is a one-cycle event when `pixel_row`==480 and `pixel_column`==0. Position only changes in vertical blanking.
- Step counter counts frame ticks 0..STEP_FRAMES-1. The tick that wraps it to 0 is a move step.
- On a move step, moving right:
  - If x_pos+4*SPACING+32+STEP_X > 640: dir flips to left, y_pos += DROP, x_pos unchanged.
  - Else x_pos += STEP_X.
- On a move step, moving left:
  - If x_pos < STEP_X: dir flips to right, y_pos += DROP.
  - Else x_pos -= STEP_X.
- `loser` sets on the first cycle where y_pos+24 >= LOSE_Y and stays high until reset. While `loser` is high, all movement freezes.
- Internal widths: x_pos and y_pos 12-bit unsigned. All compares are 12-bit unsigned with no wrap.

## Timing
- Active and output signals are combinational from the pixel inputs and registered state. There is zero latency, matching the top level's single output register.
- Reset state: x_pos=X_START, y_pos=Y_START, dir=right, step counter 0, `loser`=0.
- After reset, outputs depend only on the pixel inputs.
- Reset asserted mid-frame returns all state on the next edge. A frame tick in the same cycle as reset is ignored.
- A position update becomes visible from the first visible row of the next frame.

## Configuration
- `ALIEN_ANIM_EN` defined:
  - Adds a 1-bit pose register, reset 0, that toggles on every move step, including reversal steps.
  - Selects between two bitmaps. Both bitmaps must satisfy the bit constraints above.
- `ALIEN_ANIM_EN` undefined: single bitmap, no pose register.

## Structure
- Shared package `alien_pkg` holds:
  - Screen constants: 640, 480, tick row 480.
  - `SPRITE_W`=32, `SPRITE_H`=24.
  - The 24x32 bitmap constants (pose 0 and pose 1).
- One sub-module, `alien_sprite_rom`: combinational lookup of (pose, row[4:0], col[4:0]) returning a 1-bit value. It is instantiated once and shared by all five aliens via the offset of the matching box.

## Test plan
- Reset, pixel (row 76, col 112) -> `alien1_active`=1, others 0, `alien_output`=4'hF. Pixel (76, 176) -> `alien2_active`=1. Pixel (64, 96) -> all 0, output 0.
- Drive 8 frame ticks -> x_pos=100. Pixel (76, 116) -> `alien1_active`=1. Pixel (76, 112) is now box column 12, required to match the bitmap.
- 65 move steps from reset -> x_pos stays 352, y_pos=80, dir left. Next step -> x_pos=348.
- `LOSE_Y`=104 -> `loser` goes 1 after the first reversal (80+24 = 104). Further ticks leave position and `loser` unchanged.
- Apply `rst`=0 for one cycle mid-frame after several steps -> x_pos=96, y_pos=64, `loser`=0, and the pixel (76, 112) check passes again.
- Tick coincident with `rst`=0 -> state equals reset values. A pixel at row 480 -> all active signals 0.

Source files
------------

// File: rtl/alien_pkg.sv
// Shared constants, direction type and sprite bitmaps for the alien_row sprite generator.
// Both poses are stored here; only pose 0 is addressed unless ALIEN_ANIM_EN is defined.
package alien_pkg;

  localparam int unsigned H_RES      = 640;
  localparam int unsigned V_RES      = 480;
  localparam int unsigned TICK_ROW   = 480;
  localparam int unsigned SPRITE_W   = 32;
  localparam int unsigned SPRITE_H   = 24;
  localparam int unsigned NUM_ALIENS = 5;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  // Row 0 listed first; bit index within a row is the sprite column.
  typedef logic [0:SPRITE_H-1][SPRITE_W-1:0] bitmap_t;

  localparam bitmap_t SPRITE_POSE0 = {
    32'h00000000, 32'h00000000, 32'h00300C00, 32'h00300C00,
    32'h000C3000, 32'h000C3000, 32'h00FFFF00, 32'h00FFFF00,
    32'h03CFF3C0, 32'h03CFF3C0, 32'h0FFFFFF0, 32'h0FFFFFF0,
    32'h0FFFFFF0, 32'h0FFFFFF0, 32'h0CFFFF30, 32'h0CFFFF30,
    32'h0CC00330, 32'h0CC00330, 32'h003C3C00, 32'h003C3C00,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  localparam bitmap_t SPRITE_POSE1 = {
    32'h00000000, 32'h00000000, 32'h00C00300, 32'h00C00300,
    32'h000C3000, 32'h000C3000, 32'h00FFFF00, 32'h00FFFF00,
    32'h03CFF3C0, 32'h03CFF3C0, 32'h0FFFFFF0, 32'h0FFFFFF0,
    32'h0FFFFFF0, 32'h0FFFFFF0, 32'h0CFFFF30, 32'h0CFFFF30,
    32'h0C300C30, 32'h0C300C30, 32'h30000003, 32'h30000003,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

endpackage

// File: rtl/alien_sprite_rom.sv
// Combinational sprite bitmap lookup shared by all aliens of a row.
module alien_sprite_rom
  import alien_pkg::*;
(
  input  logic       i_pose,
  input  logic [4:0] i_row,
  input  logic [4:0] i_col,
  output logic       o_bit
);

  always_comb begin
    o_bit = 1'b0;
    if (32'(i_row) < SPRITE_H) begin
      o_bit = i_pose ? SPRITE_POSE1[i_row][i_col] : SPRITE_POSE0[i_row][i_col];
    end
  end

endmodule

// File: rtl/alien_row.sv
// One marching row of five invaders: formation position, pixel hit test and landing flag.
// Define ALIEN_ANIM_EN to add a two-pose walk animation that flips on every move step.
module alien_row
  import alien_pkg::*;
#(
  parameter int unsigned Y_START     = 64,
  parameter int unsigned X_START     = 96,
  parameter int unsigned SPACING     = 64,
  parameter int unsigned STEP_X      = 4,
  parameter int unsigned STEP_FRAMES = 8,
  parameter int unsigned DROP        = 16,
  parameter int unsigned LOSE_Y      = 400,
  parameter logic [3:0]  COLOR       = 4'hF
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  output logic [3:0]  alien_output,
  output logic        alien1_active,
  output logic        alien2_active,
  output logic        alien3_active,
  output logic        alien4_active,
  output logic        alien5_active,
  output logic        loser
);

  localparam int unsigned       STEP_W     = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEP_FRAMES - 1);
  localparam logic [11:0]       RIGHT_SPAN = 12'((NUM_ALIENS - 1) * SPACING + SPRITE_W + STEP_X);

  logic [11:0]       r_x_pos, r_y_pos, w_x_nxt, w_y_nxt;
  dir_t              r_dir, w_dir_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic              r_loser, w_loser_nxt;
  logic              w_tick, w_move, w_pose;

  assign w_tick = (pixel_row == 12'(TICK_ROW)) && (pixel_column == '0);

  always_comb begin
    w_x_nxt     = r_x_pos;
    w_y_nxt     = r_y_pos;
    w_dir_nxt   = r_dir;
    w_step_nxt  = r_step;
    w_move      = 1'b0;
    w_loser_nxt = r_loser | ((r_y_pos + 12'(SPRITE_H)) >= 12'(LOSE_Y));
    if (w_tick && !r_loser) begin
      if (r_step == STEP_LAST) begin
        w_step_nxt = '0;
        w_move     = 1'b1;
      end else begin
        w_step_nxt = r_step + STEP_W'(1);
      end
    end
    if (w_move) begin
      if (r_dir == DIR_RIGHT) begin
        if ((r_x_pos + RIGHT_SPAN) > 12'(H_RES)) begin
          w_dir_nxt = DIR_LEFT;
          w_y_nxt   = r_y_pos + 12'(DROP);
        end else begin
          w_x_nxt = r_x_pos + 12'(STEP_X);
        end
      end else begin
        if (r_x_pos < 12'(STEP_X)) begin
          w_dir_nxt = DIR_RIGHT;
          w_y_nxt   = r_y_pos + 12'(DROP);
        end else begin
          w_x_nxt = r_x_pos - 12'(STEP_X);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x_pos <= 12'(X_START);
      r_y_pos <= 12'(Y_START);
      r_dir   <= DIR_RIGHT;
      r_step  <= '0;
      r_loser <= 1'b0;
    end else begin
      r_x_pos <= w_x_nxt;
      r_y_pos <= w_y_nxt;
      r_dir   <= w_dir_nxt;
      r_step  <= w_step_nxt;
      r_loser <= w_loser_nxt;
    end
  end

`ifdef ALIEN_ANIM_EN
  logic r_pose;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pose <= 1'b0;
    end else if (w_move) begin
      r_pose <= ~r_pose;
    end
  end
  assign w_pose = r_pose;
`else
  assign w_pose = 1'b0;
`endif

  logic [11:0]           w_left [NUM_ALIENS];
  logic [NUM_ALIENS-1:0] w_in_box, w_active;
  logic                  w_row_hit, w_hit, w_bit;
  logic [4:0]            w_dx, w_dy;

  // Boxes never overlap, so the first matching box supplies the single ROM column.
  always_comb begin
    w_in_box  = '0;
    w_dx      = '0;
    w_hit     = 1'b0;
    w_dy      = 5'(pixel_row - r_y_pos);
    w_row_hit = (pixel_row < 12'(V_RES)) && (pixel_row >= r_y_pos) &&
                (pixel_row < (r_y_pos + 12'(SPRITE_H)));
    for (int unsigned i = 0; i < NUM_ALIENS; i++) begin
      w_left[i]   = r_x_pos + 12'(i * SPACING);
      w_in_box[i] = w_row_hit && (pixel_column >= w_left[i]) &&
                    (pixel_column < (w_left[i] + 12'(SPRITE_W)));
      if (w_in_box[i] && !w_hit) begin
        w_hit = 1'b1;
        w_dx  = 5'(pixel_column - w_left[i]);
      end
    end
  end

  alien_sprite_rom u_rom (
    .i_pose (w_pose),
    .i_row  (w_dy),
    .i_col  (w_dx),
    .o_bit  (w_bit)
  );

  assign w_active      = w_in_box & {NUM_ALIENS{w_bit}};
  assign alien1_active = w_active[0];
  assign alien2_active = w_active[1];
  assign alien3_active = w_active[2];
  assign alien4_active = w_active[3];
  assign alien5_active = w_active[4];
  assign alien_output  = (|w_active) ? COLOR : '0;
  assign loser         = r_loser;

endmodule

// File: tb/tb_alien_row.sv
// Directed bench for alien_row: default instance plus a LOSE_Y=104 instance on shared inputs.
module tb_alien_row;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pixel_row, pixel_column;

  logic [3:0] a_out, b_out;
  logic a1, a2, a3, a4, a5, a_loser;
  logic b1, b2, b3, b4, b5, b_loser;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  alien_row dut_a (
    .clk(clk), .rst(rst), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .alien_output(a_out), .alien1_active(a1), .alien2_active(a2), .alien3_active(a3),
    .alien4_active(a4), .alien5_active(a5), .loser(a_loser)
  );

  alien_row #(.LOSE_Y(104)) dut_b (
    .clk(clk), .rst(rst), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .alien_output(b_out), .alien1_active(b1), .alien2_active(b2), .alien3_active(b3),
    .alien4_active(b4), .alien5_active(b5), .loser(b_loser)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic probe(input string tag, input bit sel, input int r, input int c,
                       input logic [4:0] exp_act);
    logic [4:0] act;
    logic [3:0] outv;
    @(negedge clk);
    pixel_row    = 12'(r);
    pixel_column = 12'(c);
    #1;
    act  = sel ? {b5, b4, b3, b2, b1} : {a5, a4, a3, a2, a1};
    outv = sel ? b_out : a_out;
    chk({tag, ".act"}, 32'(act), 32'(exp_act));
    chk({tag, ".out"}, 32'(outv), (exp_act != 5'd0) ? 32'hF : 32'h0);
  endtask

  // Row 12 is lit over cols 4..27 and col 16 is lit over rows 6..15, so these pin x and y exactly.
  task automatic check_pos(input string tag, input bit sel, input int x, input int y);
    probe({tag, ".x_in"},  sel, y + 12, x + 4,  5'b00001);
    probe({tag, ".x_out"}, sel, y + 12, x + 3,  5'b00000);
    probe({tag, ".y_in"},  sel, y + 6,  x + 16, 5'b00001);
    probe({tag, ".y_out"}, sel, y + 5,  x + 16, 5'b00000);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pixel_row    = 12'd480;
      pixel_column = 12'd0;
      @(negedge clk);
      pixel_row    = 12'd490;
      pixel_column = 12'd7;
    end
  endtask

  initial begin
    rst          = 1'b0;
    pixel_row    = 12'd0;
    pixel_column = 12'd5;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    probe("rst_a1", 0, 76, 112, 5'b00001);
    probe("rst_a2", 0, 76, 176, 5'b00010);
    probe("rst_a5", 0, 76, 368, 5'b10000);
    probe("rst_corner", 0, 64, 96, 5'b00000);
    chk("rst_loser_a", 32'(a_loser), 32'd0);
    chk("rst_loser_b", 32'(b_loser), 32'd0);

    ticks(7);
    check_pos("tick7", 0, 96, 64);
    ticks(1);
    check_pos("step1", 0, 100, 64);
    probe("step1_c16", 0, 76, 116, 5'b00001);
    probe("step1_c12", 0, 76, 112, 5'b00001);

    ticks(63 * 8);
    check_pos("step64", 0, 352, 64);
    chk("step64_loser_b", 32'(b_loser), 32'd0);
    ticks(8);
    check_pos("step65", 0, 352, 80);
    chk("step65_loser_a", 32'(a_loser), 32'd0);
    chk("step65_loser_b", 32'(b_loser), 32'd1);
    ticks(8);
    check_pos("step66", 0, 348, 80);
    check_pos("frozen_b", 1, 352, 80);
    chk("frozen_loser_b", 32'(b_loser), 32'd1);

    ticks(3);
    @(negedge clk);
    pixel_row    = 12'd100;
    pixel_column = 12'd50;
    rst          = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_pos("midrst", 0, 96, 64);
    chk("midrst_loser_a", 32'(a_loser), 32'd0);
    chk("midrst_loser_b", 32'(b_loser), 32'd0);
    probe("midrst_c16", 0, 76, 112, 5'b00001);

    ticks(3);
    @(negedge clk);
    pixel_row    = 12'd480;
    pixel_column = 12'd0;
    rst          = 1'b0;
    @(negedge clk);
    rst          = 1'b1;
    pixel_row    = 12'd490;
    pixel_column = 12'd7;
    ticks(7);
    check_pos("tickrst7", 0, 96, 64);
    ticks(1);
    check_pos("tickrst8", 0, 100, 64);

    probe("blank_row", 0, 480, 200, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
